// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl
//   Chain of STAGES pipeline registers with stall and flush control. Register 0
//   is the youngest entry and register STAGES-1 is the oldest. Each register
//   holds a valid bit and a WIDTH-bit payload.
//
//   A stalled valid register holds its entry, and so does every valid register
//   upstream of it that is contiguous with it. An invalid register (a bubble)
//   never holds, so it always loads from upstream. A flush request at register
//   k kills every younger entry and the incoming input. A kill takes priority
//   over a hold.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous reset, active-high
//   in_valid     upstream offers in_data this cycle
//   in_data      payload entering register 0
//   in_ready     register 0 can take the input this cycle
//   stall_req    per-register stall request; ignored when that register is invalid
//   flush_req    per-register flush of all younger entries and of the input
//   stage_valid  valid bit of each register
//   stage_data   payload of each register; register k is at [k*WIDTH +: WIDTH]
//   stall_cnt    saturating count of cycles with in_valid=1 and in_ready=0
module pipe_stage_ctrl #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall_req,
    input  logic [STAGES-1:0]        flush_req,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*WIDTH-1:0]  stage_data,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic              kill_in;
    logic              hold_up;
    logic              flush_up;

    // Walk from the oldest register down. hold_up carries the hold of the
    // register just downstream. flush_up collects the flushes from all older
    // registers.
    always_comb begin
        hold     = '0;
        kill     = '0;
        hold_up  = 1'b0;
        flush_up = 1'b0;
        for (int k = STAGES-1; k >= 0; k--) begin
            hold[k]  = valid_q[k] & (stall_req[k] | hold_up);
            hold_up  = hold[k];
            kill[k]  = flush_up;
            flush_up = flush_up | flush_req[k];
        end
        kill_in = flush_up;
    end

    // When any flush is active, the input is consumed and dropped. Upstream
    // therefore sees ready even while register 0 is held.
    assign in_ready = ~hold[0] | kill_in;

    always_comb begin
        if (hold[0]) begin
            valid_d[0] = valid_q[0] & ~kill[0];
            data_d[0]  = data_q[0];
        end else begin
            valid_d[0] = in_valid & ~kill_in;
            data_d[0]  = in_data;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (hold[k]) begin
                valid_d[k] = valid_q[k] & ~kill[k];
                data_d[k]  = data_q[k];
            end else begin
                // A held source leaves a bubble behind it.
                valid_d[k] = valid_q[k-1] & ~hold[k-1] & ~kill[k];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && !in_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_flat
        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign stage_valid = valid_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
module tb_pipe_stage_ctrl;
    localparam int S  = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [S-1:0]  stall_req;
    logic [S-1:0]  flush_req;
    logic [S-1:0]  stage_valid;
    logic [S*W-1:0] stage_data;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int passed = 0;

    // Behavioural model state: one entry per register.
    bit         mv [S];
    logic [7:0] md [S];
    int         mcnt;

    pipe_stage_ctrl #(.STAGES(S), .WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
        .stage_valid(stage_valid), .stage_data(stage_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] d,
                         input logic [S-1:0] st, input logic [S-1:0] fl);
        reset = r; in_valid = v; in_data = d; stall_req = st; flush_req = fl;
    endtask

    // Check the DUT against the model, then advance both across one clock edge.
    task automatic step();
        bit         held [S];
        bit         kl [S];
        bit         kin, rdy;
        bit         nv [S];
        logic [7:0] nd [S];
        #1;
        // A register is held if it and every register from it up to some
        // stalled register are all valid.
        for (int k = 0; k < S; k++) begin
            held[k] = 1'b0;
            for (int j = k; j < S; j++) begin
                if (!mv[j]) break;
                if (stall_req[j]) begin held[k] = 1'b1; break; end
            end
            kl[k] = |(flush_req >> (k+1));
        end
        kin = |flush_req;
        rdy = !held[0] || kin;

        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("stall_cnt", {28'd0, stall_cnt}, mcnt);
        for (int k = 0; k < S; k++) begin
            chk($sformatf("valid[%0d]", k), {31'd0, stage_valid[k]}, {31'd0, mv[k]});
            if (mv[k]) chk($sformatf("data[%0d]", k), {24'd0, stage_data[k*W +: W]}, {24'd0, md[k]});
        end

        for (int k = 0; k < S; k++) begin
            if (held[k]) begin
                nv[k] = mv[k] && !kl[k]; nd[k] = md[k];
            end else if (k == 0) begin
                nv[k] = in_valid && !kin; nd[k] = in_data;
            end else begin
                nv[k] = mv[k-1] && !held[k-1] && !kl[k]; nd[k] = md[k-1];
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < S; k++) begin mv[k] = 1'b0; md[k] = 8'h00; end
            mcnt = 0;
        end else begin
            if (in_valid && !rdy && mcnt < 15) mcnt++;
            for (int k = 0; k < S; k++) begin mv[k] = nv[k]; md[k] = nd[k]; end
        end
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 8'h00, '0, '0);
        @(negedge clk);
        for (int k = 0; k < S; k++) begin mv[k] = 1'b0; md[k] = 8'h00; end
        mcnt = 0;
        chk("reset valid", {28'd0, stage_valid}, 32'h0);
        chk("reset data", stage_data, 32'h0);
        chk("reset cnt", {28'd0, stall_cnt}, 32'h0);

        // Stream 0x01..0x14 with no stall and no flush.
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 8'(i), '0, '0);
            step();
            if (i == 4) begin
                chk("stream fill valid", {28'd0, stage_valid}, 32'hF);
                chk("stream fill data", stage_data, 32'h01020304);
            end
        end
        chk("stream data", stage_data, 32'h11121314);
        chk("stream cnt", {28'd0, stall_cnt}, 32'h0);

        // Stall in the middle of the chain.
        drive(0, 1, 8'h15, 4'b0010, '0);
        #1 chk("mid stall ready", {31'd0, in_ready}, 32'h0);
        step();
        chk("mid stall valid", {28'd0, stage_valid}, 32'hB);
        chk("mid stall reg3", {24'd0, stage_data[31:24]}, 32'h12);
        chk("mid stall reg1", {24'd0, stage_data[15:8]}, 32'h13);
        chk("mid stall reg0", {24'd0, stage_data[7:0]}, 32'h14);
        chk("mid stall cnt", {28'd0, stall_cnt}, 32'h1);

        drive(1, 0, 8'h00, '0, '0);
        step();

        // Collapse a bubble in register 1 while the oldest entry is stalled.
        drive(0, 1, 8'h31, '0, '0); step();
        drive(0, 1, 8'h32, '0, '0); step();
        drive(0, 0, 8'h33, '0, '0); step();
        drive(0, 1, 8'h34, '0, '0); step();
        chk("bubble setup valid", {28'd0, stage_valid}, 32'hD);
        drive(0, 1, 8'h35, 4'b1000, '0);
        #1 chk("bubble ready", {31'd0, in_ready}, 32'h1);
        step();
        chk("bubble valid", {28'd0, stage_valid}, 32'hF);
        chk("bubble data", stage_data, 32'h31323435);

        // Flush from register 2.
        drive(0, 1, 8'h36, '0, 4'b0100);
        step();
        chk("flush valid", {28'd0, stage_valid}, 32'hC);
        chk("flush reg3", {24'd0, stage_data[31:24]}, 32'h32);
        chk("flush reg2", {24'd0, stage_data[23:16]}, 32'h34);

        // Flush takes priority over stall.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'(8'h41 + i), '0, '0);
            step();
        end
        drive(0, 1, 8'h45, 4'b0001, 4'b0010);
        #1 chk("flush over stall ready", {31'd0, in_ready}, 32'h1);
        step();
        chk("flush over stall valid", {28'd0, stage_valid}, 32'hC);
        chk("flush over stall reg3", {24'd0, stage_data[31:24]}, 32'h42);
        chk("flush over stall reg2", {24'd0, stage_data[23:16]}, 32'h43);

        // Saturate the stall counter, then reset while the stall is still held.
        drive(0, 1, 8'h50, '0, '0); step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 8'h51, 4'b0001, '0);
            step();
        end
        chk("saturated cnt", {28'd0, stall_cnt}, 32'hF);
        drive(1, 1, 8'h52, 4'b0001, '0);
        step();
        chk("mid reset valid", {28'd0, stage_valid}, 32'h0);
        chk("mid reset cnt", {28'd0, stall_cnt}, 32'h0);
        chk("mid reset data", stage_data, 32'h0);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [S-1:0] st, fl;
            for (int k = 0; k < S; k++) begin
                st[k] = ($urandom_range(0, 4) == 0);
                fl[k] = ($urandom_range(0, 19) == 0);
            end
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                  8'($urandom), st, fl);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
